// File: rtl/adder_arbiter_pkg.sv
// Shared types and constants for the adder arbiter: FSM states, default sizing,
// and the adder's saturation limits.
package adder_arbiter_pkg;

  localparam int unsigned ARB_NUM_REQ = 4;
  localparam int unsigned ARB_WIDTH   = 16;
  localparam int unsigned ARB_TIMEOUT = 15;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ISSUE   = 2'd1,
    S_WAIT    = 2'd2,
    S_RESPOND = 2'd3
  } state_t;

  // Saturated results produced by the shared adder at its two limits
  localparam logic [ARB_WIDTH-1:0] SAT_MAX = {1'b0, {(ARB_WIDTH-1){1'b1}}};
  localparam logic [ARB_WIDTH-1:0] SAT_MIN = {1'b1, {(ARB_WIDTH-1){1'b0}}};

endpackage

// File: rtl/adder_arbiter_rr_grant.sv
// Combinational round-robin picker: first requester set after i_last, with wrap.
module adder_arbiter_rr_grant
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = ARB_NUM_REQ,
  parameter int unsigned IDX_W   = $clog2(ARB_NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_last,
  output logic [NUM_REQ-1:0] o_grant_c,
  output logic [IDX_W-1:0]   o_idx_c,
  output logic               o_any_c
);

  logic [IDX_W-1:0] w_k;

  // Scan i_last+1 .. i_last+NUM_REQ (mod NUM_REQ); i_last itself is checked last
  always_comb begin
    o_grant_c = '0;
    o_idx_c   = '0;
    o_any_c   = 1'b0;
    w_k       = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      w_k = IDX_W'((32'(i_last) + i) % NUM_REQ);
      if (!o_any_c && i_req[w_k]) begin
        o_any_c        = 1'b1;
        o_idx_c        = w_k;
        o_grant_c[w_k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/adder_arbiter.sv
// Round-robin arbiter sharing one saturating adder among NUM_REQ requesters.
// Optional WAIT-state abort selected by macro ADDER_ARB_TIMEOUT_EN.
module adder_arbiter
  import adder_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = ARB_NUM_REQ,
  parameter int unsigned WIDTH   = ARB_WIDTH
`ifdef ADDER_ARB_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT = ARB_TIMEOUT
`endif
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       i_req_valid,
  output logic [NUM_REQ-1:0]       o_req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_a,
  input  logic [NUM_REQ*WIDTH-1:0] i_req_b,
  output logic [NUM_REQ-1:0]       o_rsp_valid,
  output logic [WIDTH-1:0]         o_rsp_sum,
  output logic                     o_rsp_err,
  output logic                     o_busy,
  output logic                     o_add_enable,
  output logic [WIDTH-1:0]         o_add_a,
  output logic [WIDTH-1:0]         o_add_b,
  input  logic [WIDTH-1:0]         i_add_sum,
  input  logic                     i_add_done
);

  localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t             r_state;
  logic [IDX_W-1:0]   r_last_grant;
  logic [IDX_W-1:0]   r_grant_idx;
  logic [NUM_REQ-1:0] r_rsp_valid;
  logic [WIDTH-1:0]   r_rsp_sum;
  logic               r_busy;
  logic               r_add_enable;
  logic [WIDTH-1:0]   r_add_a;
  logic [WIDTH-1:0]   r_add_b;

  logic [NUM_REQ-1:0] w_grant;
  logic [IDX_W-1:0]   w_idx;
  logic               w_any;

  adder_arbiter_rr_grant #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_grant (
    .i_req     (i_req_valid),
    .i_last    (r_last_grant),
    .o_grant_c (w_grant),
    .o_idx_c   (w_idx),
    .o_any_c   (w_any)
  );

  // Accept is combinational so the requester sees it in the cycle it is granted
  assign o_req_ready  = (r_state == S_IDLE) ? w_grant : '0;
  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_sum    = r_rsp_sum;
  assign o_busy       = r_busy;
  assign o_add_enable = r_add_enable;
  assign o_add_a      = r_add_a;
  assign o_add_b      = r_add_b;

`ifdef ADDER_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;
  logic [CNT_W-1:0] r_cnt;
  logic             r_rsp_err;
  assign o_rsp_err = r_rsp_err;
`else
  assign o_rsp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_grant_idx  <= '0;
      r_rsp_valid  <= '0;
      r_rsp_sum    <= '0;
      r_busy       <= 1'b0;
      r_add_enable <= 1'b0;
      r_add_a      <= '0;
      r_add_b      <= '0;
`ifdef ADDER_ARB_TIMEOUT_EN
      r_cnt        <= '0;
      r_rsp_err    <= 1'b0;
`endif
    end else begin
      r_add_enable <= 1'b0;
      r_rsp_valid  <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_grant_idx  <= w_idx;
            r_add_a      <= i_req_a[32'(w_idx)*WIDTH +: WIDTH];
            r_add_b      <= i_req_b[32'(w_idx)*WIDTH +: WIDTH];
            r_add_enable <= 1'b1;
            r_busy       <= 1'b1;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: begin
          // rsp_valid is loaded here so it is high exactly while in RESPOND
          if (i_add_done) begin
            r_rsp_sum   <= i_add_sum;
            r_rsp_valid <= NUM_REQ'(1) << r_grant_idx;
            r_state     <= S_RESPOND;
`ifdef ADDER_ARB_TIMEOUT_EN
            r_rsp_err   <= 1'b0;
            r_cnt       <= '0;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            r_rsp_sum   <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= NUM_REQ'(1) << r_grant_idx;
            r_cnt       <= '0;
            r_state     <= S_RESPOND;
          end else begin
            r_cnt       <= r_cnt + CNT_W'(1);
`endif
          end
        end
        S_RESPOND: begin
          r_last_grant <= r_grant_idx;
          r_busy       <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adder_arbiter.sv
// Directed bench for adder_arbiter with a 2-cycle saturating adder model.
module tb_adder_arbiter;
  import adder_arbiter_pkg::*;

  localparam int unsigned NR = ARB_NUM_REQ;
  localparam int unsigned W  = ARB_WIDTH;

  logic            clk = 1'b0;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_ready;
  logic [NR*W-1:0] req_a, req_b;
  logic [NR-1:0]   rsp_valid;
  logic [W-1:0]    rsp_sum;
  logic            rsp_err, busy, add_enable;
  logic [W-1:0]    add_a, add_b, add_sum;
  logic            add_done;

  logic [W-1:0] m_s1, m_sum;
  logic         m_v1, m_done;
  logic         stall, stray;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    int         id;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] sum;
  } vec_t;
  vec_t vecs[6];

  always #5 clk = ~clk;

  adder_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .i_req_valid  (req_valid),
    .o_req_ready  (req_ready),
    .i_req_a      (req_a),
    .i_req_b      (req_b),
    .o_rsp_valid  (rsp_valid),
    .o_rsp_sum    (rsp_sum),
    .o_rsp_err    (rsp_err),
    .o_busy       (busy),
    .o_add_enable (add_enable),
    .o_add_a      (add_a),
    .o_add_b      (add_b),
    .i_add_sum    (add_sum),
    .i_add_done   (add_done)
  );

  function automatic logic [W-1:0] sat_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W:0] s;
    s = $signed({a[W-1], a}) + $signed({b[W-1], b});
    if (s > $signed({2'b00, {(W-1){1'b1}}})) return SAT_MAX;
    if (s < $signed({2'b11, {(W-1){1'b0}}})) return SAT_MIN;
    return s[W-1:0];
  endfunction

  // Shared adder: done two cycles after enable, shares the arbiter reset
  always @(posedge clk) begin
    if (reset) begin
      m_v1 <= 1'b0; m_done <= 1'b0; m_s1 <= '0; m_sum <= '0;
    end else begin
      m_v1   <= add_enable;
      m_s1   <= sat_add(add_a, add_b);
      m_done <= m_v1 && !stall;
      m_sum  <= m_s1;
    end
  end
  assign add_done = m_done | stray;
  assign add_sum  = m_sum;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int oh2i(input logic [NR-1:0] v);
    for (int i = 0; i < int'(NR); i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; req_valid = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_ready"}, 32'(req_ready), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
    chk({tag, "_rsp_sum"}, 32'(rsp_sum), 32'h0);
    chk({tag, "_rsp_err"}, 32'(rsp_err), 32'h0);
    chk({tag, "_busy"}, 32'(busy), 32'h0);
    chk({tag, "_add_enable"}, 32'(add_enable), 32'h0);
    chk({tag, "_add_a"}, 32'(add_a), 32'h0);
    chk({tag, "_add_b"}, 32'(add_b), 32'h0);
  endtask

  // One isolated transaction; latency counted from the acceptance cycle
  task automatic run_txn(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] exp_sum, input logic exp_err, input int exp_lat);
    int k;
    bit seen;
    @(negedge clk);
    req_valid = NR'(1) << id;
    req_a[id*W +: W] = a;
    req_b[id*W +: W] = b;
    #1 chk("txn_ready", 32'(req_ready), 32'(NR'(1) << id));
    @(posedge clk);
    #1 req_valid = '0;
    seen = 1'b0;
    k = 0;
    while (!seen && k < 40) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        chk("txn_add_enable", 32'(add_enable), 32'h1);
        chk("txn_add_a", 32'(add_a), 32'(a));
        chk("txn_add_b", 32'(add_b), 32'(b));
      end
      if (rsp_valid != '0) seen = 1'b1;
    end
    chk("txn_rsp_seen", 32'(seen), 32'h1);
    chk("txn_latency", 32'(k), 32'(exp_lat));
    chk("txn_rsp_valid", 32'(rsp_valid), 32'(NR'(1) << id));
    chk("txn_rsp_sum", 32'(rsp_sum), 32'(exp_sum));
    chk("txn_rsp_err", 32'(rsp_err), 32'(exp_err));
    @(negedge clk);
    chk("txn_rsp_clear", 32'(rsp_valid), 32'h0);
    chk("txn_busy_clear", 32'(busy), 32'h0);
    chk("txn_sum_held", 32'(rsp_sum), 32'(exp_sum));
  endtask

  initial begin
    int ng, last_c, g;
    bit seen;
    reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; stall = 1'b0; stray = 1'b0;

    vecs[0] = '{0, 16'h1000, 16'h0234, 16'h1234};
    vecs[1] = '{2, 16'h7000, 16'h2000, 16'h7FFF};
    vecs[2] = '{2, 16'h8000, 16'hFFFF, 16'h8000};
    vecs[3] = '{1, 16'hFFFF, 16'h0001, 16'h0000};
    vecs[4] = '{3, 16'h8000, 16'h8000, 16'h8000};
    vecs[5] = '{1, 16'h0005, 16'hFFF0, 16'hFFF5};

    repeat (3) @(negedge clk);
    check_idle_zero("reset");
    reset = 1'b0;

    foreach (vecs[i]) run_txn(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].sum, 1'b0, 4);

    // All requesters valid from reset: strict rotation, one grant per 5 cycles
    do_reset();
    for (int i = 0; i < int'(NR); i++) begin
      req_a[i*W +: W] = W'((i + 1) * 256);
      req_b[i*W +: W] = W'(1);
    end
    req_valid = '1;
    ng = 0;
    last_c = 0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      #1;
      if (rsp_valid != '0)
        chk("rr_rsp_sum", 32'(rsp_sum), 32'((oh2i(rsp_valid) + 1) * 256 + 1));
      if (req_ready != '0) begin
        g = oh2i(req_ready);
        chk("rr_grant_order", 32'(g), 32'(ng % int'(NR)));
        if (ng > 0) chk("rr_grant_spacing", 32'(c - last_c), 32'd5);
        last_c = c;
        ng++;
      end
      @(negedge clk);
    end
    chk("rr_grant_count", 32'(ng), 32'd5);
    req_valid = '0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk);
      if (rsp_valid != '0) begin
        seen = 1'b1;
        chk("rr_last_rsp_valid", 32'(rsp_valid), 32'h1);
        chk("rr_last_rsp_sum", 32'(rsp_sum), 32'h0101);
      end
    end
    chk("rr_last_rsp_seen", 32'(seen), 32'h1);
    @(negedge clk);

    // Reset while WAITing: transaction dropped, priority restarts at requester 0
    req_valid = 4'b0010;
    req_a[1*W +: W] = 16'h0300;
    req_b[1*W +: W] = 16'h0004;
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_idle_zero("rst_wait");
    reset = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("rst_wait_no_rsp", 32'(rsp_valid), 32'h0);
    end
    req_a[0*W +: W] = 16'h0001;
    req_b[0*W +: W] = 16'h0001;
    req_valid = '1;
    #1 chk("rst_wait_grant0", 32'(req_ready), 32'h1);
    @(posedge clk);
    #1 req_valid = '0;
    repeat (4) @(negedge clk);
    chk("rst_wait_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("rst_wait_rsp_sum", 32'(rsp_sum), 32'h0002);
    @(negedge clk);

    // Stray adder completion while idle must be ignored
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    repeat (3) begin
      chk("stray_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("stray_busy", 32'(busy), 32'h0);
      @(negedge clk);
    end
    run_txn(2, 16'h0100, 16'h0200, 16'h0300, 1'b0, 4);

`ifdef ADDER_ARB_TIMEOUT_EN
    stall = 1'b1;
    run_txn(3, 16'h1111, 16'h2222, 16'h0000, 1'b1, 2 + int'(ARB_TIMEOUT));
    stall = 1'b0;
    run_txn(0, 16'h0001, 16'h0002, 16'h0003, 1'b0, 4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/adder_arbiter.md
# adder_arbiter

Round-robin arbiter that shares a single 16-bit signed saturating fixed-point adder among NUM_REQ requesters (FFT butterfly stages, magnitude accumulators, peak-pick logic). It accepts one operand pair per transaction via valid/ready, sequences the adder's enable/done protocol, and returns the saturated sum to the granted requester. It sits between the spectral-processing datapath clients and the shared adder instance.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- WIDTH, 16, operand/sum width, two's complement
- TIMEOUT, 15, max cycles in WAIT before abort (only with ADDER_ARB_TIMEOUT_EN)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing
- rsp_valid  out  NUM_REQ  one-cycle one-hot result strobe
- rsp_sum  out  WIDTH  result, valid when any rsp_valid bit set
- rsp_err  out  1  result aborted by timeout, qualified by rsp_valid
- busy  out  1  high in any state except IDLE
- add_enable  out  1  one-cycle start pulse to shared adder
- add_a, add_b  out  WIDTH  adder operands, held stable from ISSUE until RESPOND
- add_sum  in  WIDTH  adder saturated result
- add_done  in  1  adder completion strobe

## Operation
- FSM: IDLE -> ISSUE -> WAIT -> RESPOND -> IDLE.
- IDLE: if any req_valid set, grant g = first set bit searching from (last_grant+1) mod NUM_REQ upward with wrap; req_ready[g]=1 combinationally in the same cycle; capture req_a/req_b slice g and g; go to ISSUE. No valid: stay.
- ISSUE: add_enable=1 for exactly one cycle; go to WAIT.
- WAIT: on add_done capture add_sum into rsp_sum register; go to RESPOND.
- RESPOND: rsp_valid[g]=1, rsp_err=0; last_grant<=g; go to IDLE.
- req_ready is zero outside IDLE; at most one request accepted per transaction.
- Requesters hold req_valid and operands until accepted; withdrawing early is a protocol violation (not checked).
- add_done in IDLE, ISSUE or RESPOND is ignored.
- No arithmetic performed here; saturation (0x7FFF / 0x8000 for WIDTH=16) comes from the adder and passes through unchanged.
- Reset values: state IDLE, last_grant=NUM_REQ-1 (requester 0 wins first), req_ready=0, rsp_valid=0, rsp_sum=0, rsp_err=0, busy=0, add_enable=0, add_a=add_b=0, timeout counter 0.
- Reset mid-transaction: abandon it, no rsp_valid issued; the adder shares the same reset.

## Timing
- Acceptance in cycle t; add_enable high in t+1; adder returns add_done in t+3 (2-cycle adder latency); rsp_valid in t+4; IDLE in t+5, earliest next acceptance t+5.
- Throughput: one add per 5 cycles with nominal adder.
- rsp_sum held from RESPOND until next capture.
- Simultaneous requests: serviced strictly round-robin; a continuously-valid requester waits at most NUM_REQ-1 transactions.

## Configuration
- ADDER_ARB_TIMEOUT_EN defined: counter runs in WAIT; if TIMEOUT cycles elapse without add_done, go to RESPOND with rsp_err=1, rsp_sum=0; last_grant still advances. A late add_done is then ignored.
- Undefined: no counter, WAIT waits indefinitely, rsp_err tied 0.

## Structure
- Shared package: state enum (IDLE, ISSUE, WAIT, RESPOND), WIDTH default, saturation constants SAT_MAX/SAT_MIN for bench checking.
- One sub-module: rr_grant (combinational round-robin picker: req vector + last_grant -> one-hot grant and index).

## Test plan
- Single request 0, A=0x1000, B=0x0234 -> req_ready[0] at t, add_enable t+1, rsp_valid[0] at t+4, rsp_sum=0x1234.
- Req 2 with A=0x7000, B=0x2000, adder saturating -> rsp_sum=0x7FFF; A=0x8000, B=0xFFFF -> 0x8000.
- All four valid continuously after reset -> grant order 0,1,2,3,0, one acceptance every 5 cycles.
- Reset asserted during WAIT -> no rsp_valid, all outputs zero next cycle, next request granted from requester 0.
- With ADDER_ARB_TIMEOUT_EN, adder model never asserts done -> rsp_valid with rsp_err=1, rsp_sum=0, TIMEOUT cycles after entering WAIT; next requester served normally.
- Stray add_done pulse in IDLE -> no rsp_valid, state unchanged.
